// File: rtl/div_seq_pkg.sv
// Shared types and default sizes for the div_int operand sequencer.
package div_seq_pkg;

    localparam int unsigned SEQ_WIDTH = 4;
    localparam int unsigned SEQ_DEPTH = 4;
    localparam int unsigned SEQ_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    // Queued request: operands plus the tag assigned at acceptance
    typedef struct packed {
        logic [SEQ_WIDTH-1:0] x;
        logic [SEQ_WIDTH-1:0] y;
        logic [SEQ_TAG_W-1:0] tag;
    } op_t;

    // Collected divider result with the tag of its request
    typedef struct packed {
        logic [SEQ_WIDTH-1:0] q;
        logic [SEQ_WIDTH-1:0] r;
        logic                 dbz;
        logic [SEQ_TAG_W-1:0] tag;
    } res_t;

endpackage

// File: rtl/div_int.sv
// Multi-cycle restoring integer divider: start pulse in, busy while iterating, one-cycle valid out.
module div_int #(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             valid,
    output logic             dbz,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_den;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_valid;
    logic             r_dbz;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // One restoring step: shift in the next dividend bit and try to subtract
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_den});
    assign w_diff  = WIDTH'(w_shift - {1'b0, r_den});

    // Iteration control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_den   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (start && !r_busy) begin
                r_quo  <= x;
                r_rem  <= '0;
                r_den  <= y;
                r_dbz  <= (y == '0);
                r_cnt  <= CNT_W'(WIDTH);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign dbz   = r_dbz;
    assign q     = r_quo;
    assign r     = r_rem;

endmodule

// File: rtl/div_seq_fifo.sv
// Synchronous FIFO of op_t requests; count is the only status register.
module div_seq_fifo
    import div_seq_pkg::*;
#(
    parameter  int unsigned DEPTH = SEQ_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  op_t              i_data,
    input  logic             i_pop,
    output op_t              o_head_c,
    output logic [CNT_W-1:0] o_count
);

    op_t              r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // A push into a full FIFO is dropped here; the producer is gated by count anyway
    assign w_wr_en = i_push && !w_full;
    assign w_rd_en = i_pop && !w_empty;

    // Storage array, no reset needed: entries are only read when counted valid
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_count  = r_count;

endmodule

// File: rtl/div_int_seq.sv
// Operand sequencer and result collector wrapped around div_int.
module div_int_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH,
    parameter int unsigned DEPTH = SEQ_DEPTH,
    parameter int unsigned TAG_W = SEQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             div_start,
    output logic [WIDTH-1:0] div_x,
    output logic [WIDTH-1:0] div_y,
    input  logic             div_busy,
    input  logic             div_valid,
    input  logic             div_dbz,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_q,
    output logic [WIDTH-1:0] res_r,
    output logic             res_dbz,
    output logic [TAG_W-1:0] res_tag
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [TAG_W-1:0] r_in_tag;
    logic [TAG_W-1:0] r_iss_tag;
    logic             r_div_start;
    logic [WIDTH-1:0] r_div_x;
    logic [WIDTH-1:0] r_div_y;
    res_t             r_res;
    logic             r_res_valid;
    op_t              w_push_op;
    op_t              w_head;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic             w_capture;

    // in_ready depends on the FIFO count register alone
    assign in_ready     = (w_fifo_count != CNT_W'(DEPTH));
    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_push       = in_valid && in_ready;
    assign w_push_op    = '{x: in_x, y: in_y, tag: r_in_tag};

    div_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_data   (w_push_op),
        .i_pop    (w_pop),
        .o_head_c (w_head),
        .o_count  (w_fifo_count)
    );

    // Acceptance-order tag, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_tag <= '0;
        end else if (w_push) begin
            r_in_tag <= r_in_tag + TAG_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and control strobes; issue only when the result slot will be free
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_fifo_empty && !div_busy && (!r_res_valid || res_ready)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_pop       = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (div_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Divider-side registers: operands loaded entering ISSUE so they are valid with the start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_start <= 1'b0;
            r_div_x     <= '0;
            r_div_y     <= '0;
            r_iss_tag   <= '0;
        end else begin
            r_div_start <= w_issue;
            if (w_issue) begin
                r_div_x   <= w_head.x;
                r_div_y   <= w_head.y;
                r_iss_tag <= w_head.tag;
            end
        end
    end

    // Result holding register; capture wins over drain so drain+reload keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_capture) begin
                r_res       <= '{q: div_q, r: div_r, dbz: div_dbz, tag: r_iss_tag};
                r_res_valid <= 1'b1;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign div_start = r_div_start;
    assign div_x     = r_div_x;
    assign div_y     = r_div_y;
    assign res_valid = r_res_valid;
    assign res_q     = r_res.q;
    assign res_r     = r_res.r;
    assign res_dbz   = r_res.dbz;
    assign res_tag   = r_res.tag;

endmodule

// File: tb/tb_div_int_seq.sv
// Scoreboard bench for div_int_seq driving a real div_int.
`timescale 1ns/1ps
module tb_div_int_seq;

    localparam int unsigned W     = 4;
    localparam int unsigned TW    = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_y = '0;
    logic          div_start;
    logic [W-1:0]  div_x;
    logic [W-1:0]  div_y;
    logic          div_busy;
    logic          div_valid_core;
    logic          div_valid;
    logic          div_dbz;
    logic [W-1:0]  div_q;
    logic [W-1:0]  div_r;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [W-1:0]  res_q;
    logic [W-1:0]  res_r;
    logic          res_dbz;
    logic [TW-1:0] res_tag;
    logic          stray_valid = 1'b0;

    // Injected valid pulses model a divider response left over from before a reset
    assign div_valid = div_valid_core | stray_valid;

    always #5 clk = ~clk;

    div_int_seq #(.WIDTH(W), .DEPTH(DEPTH), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .div_start(div_start), .div_x(div_x), .div_y(div_y),
        .div_busy(div_busy), .div_valid(div_valid), .div_dbz(div_dbz),
        .div_q(div_q), .div_r(div_r),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .res_r(res_r), .res_dbz(res_dbz), .res_tag(res_tag)
    );

    div_int #(.WIDTH(W)) u_div (
        .clk(clk), .rst_n(rst_n), .start(div_start), .x(div_x), .y(div_y),
        .busy(div_busy), .valid(div_valid_core), .dbz(div_dbz), .q(div_q), .r(div_r)
    );

    typedef struct {
        int unsigned q;
        int unsigned r;
        bit          dbz;
        int unsigned tag;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_results = 0;
    int            n_starts = 0;
    int            n_valid_cycles = 0;
    logic [TW-1:0] tb_tag = '0;
    logic [W-1:0]  start_x = '0;
    logic [W-1:0]  start_y = '0;
    bit            rnd_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour: integer division, divide-by-zero flagged
    function automatic exp_t model(input int unsigned x, input int unsigned y, input int unsigned tag);
        exp_t e;
        e.tag = tag;
        e.dbz = (y == 0);
        e.q   = (y == 0) ? 0 : x / y;
        e.r   = (y == 0) ? 0 : x % y;
        return e;
    endfunction

    // Offer one operand pair; expected result is queued when the transfer is certain
    task automatic push(input int unsigned x, input int unsigned y);
        int budget;
        in_valid = 1'b1;
        in_x     = W'(x);
        in_y     = W'(y);
        budget   = 0;
        while (!in_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
        end else begin
            sb.push_back(model(x, y, int'(tb_tag)));
            tb_tag = tb_tag + TW'(1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((sb.size() != 0 || res_valid) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check(name, sb.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: protocol checks and scoreboard compare, sampled mid-low-phase
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (div_start) begin
                check("start_while_busy", int'(div_busy), 0);
                n_starts++;
                start_x = div_x;
                start_y = div_y;
            end
            if (div_valid_core) begin
                check("div_x_hold", int'(div_x), int'(start_x));
                check("div_y_hold", int'(div_y), int'(start_y));
            end
            if (res_valid) n_valid_cycles++;
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("res_tag", int'(res_tag), int'(mon_e.tag));
                    check("res_dbz", int'(res_dbz), int'(mon_e.dbz));
                    if (!mon_e.dbz) begin
                        check("res_q", int'(res_q), int'(mon_e.q));
                        check("res_r", int'(res_r), int'(mon_e.r));
                    end
                    n_results++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    int base_res;
    int base_start;
    int base_vc;

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_div_start", int'(div_start), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single op 7/2 with latency and one-cycle valid
        base_start = n_starts; base_vc = n_valid_cycles;
        push(7, 2);
        #1 check("lat_pre_start", int'(div_start), 0);
        @(negedge clk);
        #1 check("lat_start", int'(div_start), 1);
        wait_drain("t1_drain");
        check("t1_starts", n_starts - base_start, 1);
        check("t1_valid_cycles", n_valid_cycles - base_vc, 1);

        // 2: back-to-back ops including divide by zero
        base_start = n_starts; base_res = n_results;
        push(0, 2); push(2, 0); push(15, 5); push(8, 9);
        wait_drain("t2_drain");
        check("t2_starts", n_starts - base_start, 4);
        check("t2_results", n_results - base_res, 4);

        // 3 + 6: consumer stalled, FIFO fills, then push lands on a full-FIFO pop
        base_start = n_starts; base_res = n_results;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(i + 3, 1);
        repeat (20) @(negedge clk);
        #1;
        check("t3_in_ready_full", int'(in_ready), 0);
        check("t3_res_held", int'(res_valid), 1);
        check("t3_held_tag", int'(res_tag), int'(sb[0].tag));
        check("t3_no_delivery", n_results - base_res, 0);
        check("t3_one_start", n_starts - base_start, 1);
        @(negedge clk);
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = W'(13);
        in_y      = W'(4);
        @(negedge clk);
        #1 check("t6_stall_on_pop", int'(in_ready), 0);
        push(13, 4);
        wait_drain("t3_drain");
        check("t3_results", n_results - base_res, 6);
        check("t3_starts", n_starts - base_start, 6);

        // 4: reset during WAIT with more ops queued
        push(15, 5); push(3, 1); push(4, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("r4_div_start", int'(div_start), 0);
        check("r4_div_x", int'(div_x), 0);
        check("r4_div_y", int'(div_y), 0);
        check("r4_res_valid", int'(res_valid), 0);
        check("r4_res_q", int'(res_q), 0);
        check("r4_res_r", int'(res_r), 0);
        check("r4_res_dbz", int'(res_dbz), 0);
        check("r4_res_tag", int'(res_tag), 0);
        sb.delete();
        tb_tag = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("r4_in_ready", int'(in_ready), 1);
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        #1 check("r4_stray_ignored", int'(res_valid), 0);
        repeat (8) @(negedge clk);
        #1 check("r4_no_old_result", int'(res_valid), 0);
        check("r4_no_start", int'(div_start), 0);
        push(1, 1);
        wait_drain("t4_drain");

        // 5: tag wrap over 2**TW+1 ops
        base_res = n_results;
        for (int i = 0; i < (1 << TW) + 1; i++) push(1, 1);
        wait_drain("t5_drain");
        check("t5_results", n_results - base_res, (1 << TW) + 1);

        // Randomized traffic with random consumer backpressure
        base_res = n_results;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    push($urandom_range(0, 15), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15));
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    res_ready = ($urandom_range(0, 3) != 0);
                end
                res_ready = 1'b1;
            end
        join
        wait_drain("rnd_drain");
        check("rnd_results", n_results - base_res, 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
